// File: rtl/decoder_pkg.sv
// Shared types and defaults for the output-side AER decoder.
package decoder_pkg;

  localparam int N_CLASSES_D = 10;
  localparam int TIMEOUT_D   = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LISTEN = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } dec_state_t;

  typedef enum logic {
    H_WAIT = 1'b0,
    H_ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/decoder_aer_out.sv
// AER receiver: REQ synchronizer, 4-phase handshake, one event per request.
module decoder_aer_out
  import decoder_pkg::*;
#(
  parameter int AER_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req,
  input  logic [AER_BITS-1:0] i_addr,
  output logic                o_ack,
  output logic                o_evt_valid,
  output logic [AER_BITS-1:0] o_evt_addr
);

  logic                r_req_s1;
  logic                r_req_s2;
  hs_state_t           r_hs;
  logic                r_ack;
  logic                r_evt;
  logic [AER_BITS-1:0] r_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
      r_hs     <= H_WAIT;
      r_ack    <= 1'b0;
      r_evt    <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_req_s1 <= i_req;
      r_req_s2 <= r_req_s1;
      r_evt    <= 1'b0;
      unique case (r_hs)
        H_WAIT: if (r_req_s2) begin
          r_addr <= i_addr;
          r_ack  <= 1'b1;
          r_evt  <= 1'b1;
          r_hs   <= H_ACK;
        end
        H_ACK: if (!r_req_s2) begin
          r_ack <= 1'b0;
          r_hs  <= H_WAIT;
        end
        default: r_hs <= H_WAIT;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_evt_valid = r_evt;
  assign o_evt_addr  = r_addr;

endmodule

// File: rtl/decoder.sv
// Output-layer spike decoder: per-class counters, threshold win,
// timeout argmax fallback and the INFERENCE_DONE pulse.
module decoder
  import decoder_pkg::*;
#(
  parameter int N_CLASSES       = N_CLASSES_D,
  parameter int CLASS_BITS      = $clog2(N_CLASSES),
  parameter int AER_BITS        = 8,
  parameter int SPIKE_THRESHOLD = 1,
  parameter int CNT_BITS        = $clog2(SPIKE_THRESHOLD + 1),
  parameter int TIMEOUT         = TIMEOUT_D
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [AER_BITS-1:0]   AEROUT_ADDR,
  input  logic                  AEROUT_REQ,
  output logic                  AEROUT_ACK,
  input  logic                  NEW_IMAGE,
  input  logic                  IMAGE_ENCODED,
  output logic                  INFERENCE_DONE,
  output logic [CLASS_BITS-1:0] INFERRED_DIGIT,
  output logic                  NO_SPIKE,
  output logic                  DECODER_BUSY
);

  localparam int TMR_BITS = $clog2(TIMEOUT + 1);
  localparam logic [CNT_BITS-1:0] THR   = CNT_BITS'(SPIKE_THRESHOLD);
  localparam logic [CNT_BITS-1:0] THR_M = CNT_BITS'(SPIKE_THRESHOLD - 1);

  logic                  w_evt_valid;
  logic [AER_BITS-1:0]   w_evt_addr;
  logic                  w_active;
  logic                  w_in_range;
  logic [CLASS_BITS-1:0] w_idx;
  logic [CNT_BITS-1:0]   w_cur;
  logic [CNT_BITS-1:0]   w_next;
  logic                  w_count;
  logic                  w_hit;
  logic                  w_enc_rise;
  logic [CLASS_BITS-1:0] w_best_idx;
  logic [CNT_BITS-1:0]   w_best_cnt;

  dec_state_t            r_state;
  logic [CNT_BITS-1:0]   r_cnt [N_CLASSES];
  logic [TMR_BITS-1:0]   r_tmr;
  logic                  r_enc_q;
  logic                  r_done;
  logic [CLASS_BITS-1:0] r_digit;
  logic                  r_nospike;

  decoder_aer_out #(
    .AER_BITS (AER_BITS)
  ) u_aer_out (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_req       (AEROUT_REQ),
    .i_addr      (AEROUT_ADDR),
    .o_ack       (AEROUT_ACK),
    .o_evt_valid (w_evt_valid),
    .o_evt_addr  (w_evt_addr)
  );

  assign w_active   = (r_state == LISTEN) || (r_state == DRAIN);
  assign w_in_range = w_evt_addr < AER_BITS'(N_CLASSES);
  assign w_idx      = w_evt_addr[CLASS_BITS-1:0];
  assign w_enc_rise = IMAGE_ENCODED && !r_enc_q;
  assign w_count    = w_evt_valid && w_in_range && w_active && !NEW_IMAGE;

  always_comb begin
    w_cur = '0;
    if (w_in_range) w_cur = r_cnt[w_idx];
  end

  assign w_next = (w_cur == THR) ? w_cur : w_cur + CNT_BITS'(1);
  assign w_hit  = w_count && (w_cur == THR_M);

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_best_idx = '0;
    w_best_cnt = r_cnt[0];
    for (int i = 1; i < N_CLASSES; i++) begin
      if (r_cnt[i] > w_best_cnt) begin
        w_best_cnt = r_cnt[i];
        w_best_idx = CLASS_BITS'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_tmr     <= '0;
      r_enc_q   <= 1'b0;
      r_done    <= 1'b0;
      r_digit   <= '0;
      r_nospike <= 1'b0;
      for (int i = 0; i < N_CLASSES; i++) r_cnt[i] <= '0;
    end else begin
      r_enc_q <= IMAGE_ENCODED;
      r_done  <= 1'b0;
      if (NEW_IMAGE) begin
        r_state   <= LISTEN;
        r_digit   <= '0;
        r_nospike <= 1'b0;
        for (int i = 0; i < N_CLASSES; i++) r_cnt[i] <= '0;
      end else if (w_active) begin
        if (w_count) r_cnt[w_idx] <= w_next;
        if (w_hit) begin
          r_digit <= w_idx;
          r_done  <= 1'b1;
          r_state <= DONE;
        end else if (r_state == LISTEN) begin
          if (w_enc_rise) begin
            r_tmr   <= TMR_BITS'(TIMEOUT - 1);
            r_state <= DRAIN;
          end
        end else if (r_tmr == '0) begin
          r_digit   <= w_best_idx;
          r_nospike <= (w_best_cnt == '0);
          r_done    <= 1'b1;
          r_state   <= DONE;
        end else begin
          r_tmr <= r_tmr - TMR_BITS'(1);
        end
      end
    end
  end

  assign INFERENCE_DONE = r_done;
  assign INFERRED_DIGIT = r_digit;
  assign NO_SPIKE       = r_nospike;
  assign DECODER_BUSY   = w_active;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: handshake timing, threshold win,
// timeout argmax, no-spike, abort, reset and idle traffic.
module tb_decoder;

  localparam int NC  = 10;
  localparam int CB  = 4;
  localparam int AB  = 8;
  localparam int THR = 3;
  localparam int TO  = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AB-1:0] AEROUT_ADDR = '0;
  logic          AEROUT_REQ = 1'b0;
  logic          NEW_IMAGE = 1'b0;
  logic          IMAGE_ENCODED = 1'b0;
  logic          AEROUT_ACK;
  logic          INFERENCE_DONE;
  logic [CB-1:0] INFERRED_DIGIT;
  logic          NO_SPIKE;
  logic          DECODER_BUSY;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;
  int d0     = 0;

  decoder #(
    .N_CLASSES       (NC),
    .CLASS_BITS      (CB),
    .AER_BITS        (AB),
    .SPIKE_THRESHOLD (THR),
    .CNT_BITS        (2),
    .TIMEOUT         (TO)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .AEROUT_ADDR    (AEROUT_ADDR),
    .AEROUT_REQ     (AEROUT_REQ),
    .AEROUT_ACK     (AEROUT_ACK),
    .NEW_IMAGE      (NEW_IMAGE),
    .IMAGE_ENCODED  (IMAGE_ENCODED),
    .INFERENCE_DONE (INFERENCE_DONE),
    .INFERRED_DIGIT (INFERRED_DIGIT),
    .NO_SPIKE       (NO_SPIKE),
    .DECODER_BUSY   (DECODER_BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (INFERENCE_DONE === 1'b1) n_done++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [AB-1:0] a);
    int k;
    AEROUT_ADDR = a;
    AEROUT_REQ  = 1'b1;
    k = 0;
    while (AEROUT_ACK !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk("ack_rise", 32'(AEROUT_ACK), 1);
    AEROUT_REQ = 1'b0;
    k = 0;
    while (AEROUT_ACK !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    chk("ack_fall", 32'(AEROUT_ACK), 0);
    tick();
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (INFERENCE_DONE !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(INFERENCE_DONE), 1);
  endtask

  task automatic new_image();
    NEW_IMAGE = 1'b1;
    tick();
    NEW_IMAGE = 1'b0;
  endtask

  initial begin
    // reset values
    tick(3);
    chk("rst_ack", 32'(AEROUT_ACK), 0);
    chk("rst_done", 32'(INFERENCE_DONE), 0);
    chk("rst_digit", 32'(INFERRED_DIGIT), 0);
    chk("rst_nospike", 32'(NO_SPIKE), 0);
    chk("rst_busy", 32'(DECODER_BUSY), 0);
    RST = 1'b0;
    tick();

    // idle traffic is acked, not counted
    d0 = n_done;
    send(8'd3);
    tick(2);
    chk("idle_ndone", 32'(n_done), 32'(d0));
    chk("idle_busy", 32'(DECODER_BUSY), 0);
    chk("idle_digit", 32'(INFERRED_DIGIT), 0);

    // threshold win on class 5; 18 and 12 out of range
    new_image();
    chk("listen_busy", 32'(DECODER_BUSY), 1);
    d0 = n_done;
    send(8'd2);
    send(8'd5);
    send(8'd2);
    send(8'd18);
    send(8'd12);
    send(8'd5);
    chk("thr_nodone", 32'(n_done), 32'(d0));
    AEROUT_ADDR = 8'd5;
    AEROUT_REQ  = 1'b1;
    tick(2);
    chk("ack_t2", 32'(AEROUT_ACK), 0);
    tick();
    chk("ack_t3", 32'(AEROUT_ACK), 1);
    chk("done_t3", 32'(INFERENCE_DONE), 0);
    tick();
    chk("done_t4", 32'(INFERENCE_DONE), 1);
    chk("thr_digit", 32'(INFERRED_DIGIT), 5);
    tick();
    chk("done_pulse", 32'(INFERENCE_DONE), 0);
    AEROUT_REQ = 1'b0;
    tick(2);
    chk("ackf_t2", 32'(AEROUT_ACK), 1);
    tick();
    chk("ackf_t3", 32'(AEROUT_ACK), 0);
    chk("thr_ndone", 32'(n_done), 32'(d0 + 1));
    chk("done_busy", 32'(DECODER_BUSY), 0);

    // traffic in DONE leaves result alone
    send(8'd5);
    send(8'd1);
    chk("donest_digit", 32'(INFERRED_DIGIT), 5);
    chk("donest_ndone", 32'(n_done), 32'(d0 + 1));

    // timeout argmax: 3,3,6 -> 3
    new_image();
    chk("clear_digit", 32'(INFERRED_DIGIT), 0);
    send(8'd3);
    send(8'd3);
    send(8'd6);
    d0 = n_done;
    IMAGE_ENCODED = 1'b1;
    tick(TO);
    chk("to_early", 32'(INFERENCE_DONE), 0);
    chk("to_ndone", 32'(n_done), 32'(d0));
    chk("drain_busy", 32'(DECODER_BUSY), 1);
    tick();
    chk("to_done", 32'(INFERENCE_DONE), 1);
    chk("to_digit", 32'(INFERRED_DIGIT), 3);
    chk("to_nospike", 32'(NO_SPIKE), 0);
    IMAGE_ENCODED = 1'b0;
    tick();

    // tie 4,4,1,1 -> lowest index 1
    new_image();
    send(8'd4);
    send(8'd4);
    send(8'd1);
    send(8'd1);
    IMAGE_ENCODED = 1'b1;
    wait_done(TO + 10);
    chk("tie_digit", 32'(INFERRED_DIGIT), 1);
    IMAGE_ENCODED = 1'b0;
    tick();

    // no spikes
    new_image();
    tick();
    IMAGE_ENCODED = 1'b1;
    wait_done(TO + 10);
    chk("ns_nospike", 32'(NO_SPIKE), 1);
    chk("ns_digit", 32'(INFERRED_DIGIT), 0);
    IMAGE_ENCODED = 1'b0;
    tick(2);
    chk("ns_pulse", 32'(INFERENCE_DONE), 0);

    // abort clears counters
    new_image();
    send(8'd9);
    send(8'd9);
    d0 = n_done;
    new_image();
    chk("abort_busy", 32'(DECODER_BUSY), 1);
    send(8'd9);
    send(8'd9);
    tick(2);
    chk("abort_ndone", 32'(n_done), 32'(d0));
    send(8'd9);
    tick(2);
    chk("abort_win", 32'(n_done), 32'(d0 + 1));
    chk("abort_digit", 32'(INFERRED_DIGIT), 9);

    // reset while ACK high
    new_image();
    AEROUT_ADDR = 8'd0;
    AEROUT_REQ  = 1'b1;
    tick(3);
    chk("mid_ack", 32'(AEROUT_ACK), 1);
    RST = 1'b1;
    tick();
    chk("rst_mid_ack", 32'(AEROUT_ACK), 0);
    chk("rst_mid_busy", 32'(DECODER_BUSY), 0);
    chk("rst_mid_digit", 32'(INFERRED_DIGIT), 0);
    RST = 1'b0;
    AEROUT_REQ = 1'b0;
    tick(4);
    chk("post_rst_ack", 32'(AEROUT_ACK), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
